// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared phase encodings, opcodes and reset PC for the multi-cycle core
package pc_fetch_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3
  } phase_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_npc_calc.sv
// rtl/pc_fetch_npc_calc.sv - combinational branch/jump target and taken decision
module npc_calc (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] ir,
  input  logic [31:0] rs_data,
  input  logic        j_en,
  input  logic        bgtz_en,
  output logic [31:0] target,
  output logic        taken
);

  logic [31:0] j_target;
  logic [31:0] b_target;
  logic        rs_gt_zero;
  logic        unused_opcode;

  assign unused_opcode = &{1'b0, ir[31:26]};

  assign j_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
  assign b_target   = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign rs_gt_zero = !rs_data[31] && (rs_data != 32'd0);

  // Jump has priority when the control unit raises both qualifiers.
  assign target = j_en ? j_target : b_target;
  assign taken  = j_en || (bgtz_en && rs_gt_zero);

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC, instruction register and next-PC selection; optional FETCH_RETIRE_CNT_EN
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] curr_state,
  input  logic               Branch,
  input  logic               j_en,
  input  logic               bgtz_en,
  input  logic [31:0]        rs_data,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        ir,
  output logic [5:0]         instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               redirect,
`ifdef FETCH_RETIRE_CNT_EN
  output logic [31:0]        retire_cnt,
`endif
  output logic               range_err
);

  logic [31:0] target;
  logic [31:0] npc_target;
  logic        npc_taken;
  logic [31:0] next_pc;
  logic        is_s0;
  logic        is_s2;
  logic        is_s3;
  logic        next_out_of_range;

  assign is_s0 = (curr_state == S0);
  assign is_s2 = (curr_state == S2);
  assign is_s3 = (curr_state == S3);

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];
  assign instr     = ir[31:26];
  assign next_pc   = redirect ? target : pc_plus4;

  // Any bit above the word-address field means the fetch lands outside imem.
  assign next_out_of_range = ((next_pc >> (IMEM_AW + 2)) != 32'd0);

  npc_calc u_npc_calc (
    .pc_plus4 (pc_plus4),
    .ir       (ir),
    .rs_data  (rs_data),
    .j_en     (j_en),
    .bgtz_en  (bgtz_en),
    .target   (npc_target),
    .taken    (npc_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= 32'd0;
    end else if (is_s0) begin
      ir <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target   <= 32'd0;
      redirect <= 1'b0;
    end else if (is_s2 && Branch) begin
      redirect <= npc_taken;
      if (npc_taken) begin
        target <= npc_target;
      end
    end else if (is_s3) begin
      redirect <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      range_err <= 1'b0;
    end else if (is_s3) begin
      pc <= next_pc;
      if (next_out_of_range) begin
        range_err <= 1'b1;
      end
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 32'd0;
    end else if (is_s3) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch stage for the four-phase multi-cycle MIPS core, directly upstream of the control unit.
- Holds the PC and the instruction register, and drives the instruction-memory address.
- Feeds the opcode field to the control unit.
- Consumes the control unit's Branch/j_en/bgtz_en strobes to select the next PC (sequential, BGTZ target or J target).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 8, instruction-memory word-address width. Memory depth is 2^IMEM_AW words.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- curr_state  in  3  control-unit phase: 0=S0 fetch, 1=S1 decode, 2=S2 execute, 3=S3 writeback
- Branch  in  1  control-unit branch/jump strobe, high during S2
- j_en  in  1  jump-type qualifier from the control unit
- bgtz_en  in  1  BGTZ qualifier from the control unit
- rs_data  in  32  register-file read of the rs field, valid during S2
- imem_addr  out  IMEM_AW  word address to the combinational-read instruction memory, equal to pc[IMEM_AW+1:2]
- imem_rdata  in  32  instruction word returned the same cycle
- ir  out  32  instruction register
- instr  out  6  ir[31:26], opcode to the control unit
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational, modulo 2^32
- redirect  out  1  registered; high during S3 when a taken branch or jump is pending
- range_err  out  1  sticky; next PC falls outside instruction memory

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC, ir=0 (so instr=6'b000000), redirect=0, range_err=0, target register=0.
  - Asserting rst_n low in any phase aborts the instruction in flight; no partial PC update survives.
- Fetch: on the rising edge where curr_state==S0, ir <= imem_rdata. ir is then stable through S1..S3, so the control unit decodes it on its S1 edge. ir is not written in any other phase.
- Branch resolution: on the rising edge where curr_state==S2 and Branch==1:
  - j_en==1: target <= {pc_plus4[31:28], ir[25:0], 2'b00}; redirect <= 1.
  - bgtz_en==1 and rs_data is signed > 0 (rs_data[31]==0 and rs_data!=0): target <= pc_plus4 + ({{14{ir[15]}}, ir[15:0], 2'b00}); redirect <= 1.
  - bgtz_en==1 with rs_data<=0: redirect <= 0 (not taken).
  - j_en and bgtz_en both high: j_en wins.
  - Branch high outside S2: ignored.
- PC update: on the rising edge where curr_state==S3:
  - pc <= redirect ? target : pc_plus4.
  - redirect cleared on the same edge.
  - Exactly one PC update per four-phase instruction.
- Wrap-around: pc_plus4 and branch arithmetic are modulo 2^32. PC 32'hFFFF_FFFC advances to 0.
- range_err: set on the S3 edge if the new pc has any bit set in [31:IMEM_AW+2]. Cleared only by reset. pc still loads the out-of-range value; imem_addr truncates.
- curr_state values 4..7 are treated as no-ops: no register updates.
- Latency: fetch-to-decode 1 cycle; branch decision to PC 1 cycle; instruction period 4 cycles.

Optional Feature:
- Macro FETCH_RETIRE_CNT_EN.
- Defined: adds output retire_cnt[31:0]. Reset to 0. Increments by 1 on every S3 edge and wraps at 2^32.
- Undefined: the port is absent and no counter logic is built.

Decomposition:
- Shared package (used by the control unit too):
  - phase encodings S0..S3 and phase width 3;
  - opcode constants ADD, ADDI, SW, LW, BGTZ, J, LUI, ORI;
  - RESET_PC default.
- Sub-module npc_calc (combinational): takes pc_plus4, ir, rs_data, j_en, bgtz_en; produces target and taken. pc_fetch keeps all registers and the phase decoding.

Test Plan:
- Reset release with RESET_PC=0 and imem[0]=32'h2008_0005 -> after the S0 edge ir=32'h2008_0005, instr=6'b001000; after the S3 edge pc=4.
- Straight-line run of 3 ADDs -> pc sequence 0,4,8,12 at successive S3 edges; redirect stays 0.
- J with ir=32'h0800_0010 at pc=8 -> redirect=1 in S3; pc=32'h0000_0040 after the S3 edge.
- BGTZ with imm=16'hFFFE at pc=16: rs_data=5 -> pc=12; rs_data=0 -> pc=20; rs_data=32'h8000_0000 -> pc=20.
- Jump to 32'h0000_0800 with IMEM_AW=8 -> range_err=1 and sticky; a later sequential fetch leaves it set; rst_n low clears it.
- rst_n pulsed low during S2 of a taken BGTZ -> pc=RESET_PC, redirect=0, ir=0. The following S0 fetches imem[RESET_PC>>2]. With FETCH_RETIRE_CNT_EN, retire_cnt=0.
